// File: rtl/fw_loader.sv
// rtl/fw_loader.sv - byte-stream firmware loader driving the progmem write port
module fw_loader #(
  parameter int         MEM_WORDS   = 8192,
  parameter int         BASE_WORD   = 0,
  parameter int         TIMEOUT_CYC = 1000000,
  parameter logic [7:0] MAGIC       = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_valid,
  input  logic [7:0]  rx_data,
  output logic        rx_ready,
  output logic        mem_wen,
  output logic [31:0] mem_waddr,
  output logic [31:0] mem_wdata,
  output logic        cpu_rst,
  output logic        busy,
  output logic        done,
  output logic [1:0]  err
);

  typedef enum logic [2:0] {
    S_IDLE, S_CNT_L, S_CNT_H, S_DATA, S_CSUM, S_DONE, S_ERROR
  } state_t;

  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  localparam logic [1:0] ERR_NONE  = 2'd0;
  localparam logic [1:0] ERR_CSUM  = 2'd1;
  localparam logic [1:0] ERR_COUNT = 2'd2;
  localparam logic [1:0] ERR_TMO   = 2'd3;

  state_t        state_q, state_d;
  logic [15:0]   cnt_q, cnt_d;
  logic [15:0]   word_idx_q, word_idx_d;
  logic [1:0]    byte_idx_q, byte_idx_d;
  logic [23:0]   wbuf_q, wbuf_d;
  logic [7:0]    sum_q, sum_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          wen_q, wen_d;
  logic [31:0]   waddr_q, waddr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic          cpu_rst_q, cpu_rst_d;
  logic          busy_q, busy_d;
  logic          done_q, done_d;
  logic [1:0]    err_q, err_d;

  logic          in_frame;
  logic          tmo_expire;
  logic [15:0]   cnt_full;

  // The loader never back-pressures the byte source.
  assign rx_ready  = 1'b1;
  assign mem_wen   = wen_q;
  assign mem_waddr = waddr_q;
  assign mem_wdata = wdata_q;
  assign cpu_rst   = cpu_rst_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;

  assign in_frame   = (state_q == S_CNT_L) || (state_q == S_CNT_H) ||
                      (state_q == S_DATA)  || (state_q == S_CSUM);
  assign tmo_expire = in_frame && (tmo_q == TMO_LAST);
  assign cnt_full   = {rx_data, cnt_q[7:0]};

  // Next-state, frame parsing, word assembly and output register updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_idx_d = word_idx_q;
    byte_idx_d = byte_idx_q;
    wbuf_d     = wbuf_q;
    sum_d      = sum_q;
    tmo_d      = '0;
    wen_d      = 1'b0;
    waddr_d    = waddr_q;
    wdata_d    = wdata_q;
    cpu_rst_d  = cpu_rst_q;
    busy_d     = busy_q;
    done_d     = done_q;
    err_d      = err_q;

    if (in_frame && !rx_valid) begin
      tmo_d = tmo_q + 1'b1;
    end

    if (tmo_expire) begin
      // An expiring timeout takes priority over a byte arriving the same cycle.
      state_d = S_ERROR;
      err_d   = ERR_TMO;
      busy_d  = 1'b0;
      tmo_d   = '0;
    end else if (rx_valid) begin
      case (state_q)
        S_IDLE, S_DONE, S_ERROR: begin
          if (rx_data == MAGIC) begin
            state_d   = S_CNT_L;
            busy_d    = 1'b1;
            cpu_rst_d = 1'b1;
            done_d    = 1'b0;
            err_d     = ERR_NONE;
            sum_d     = 8'd0;
          end
        end
        S_CNT_L: begin
          cnt_d[7:0] = rx_data;
          sum_d      = sum_q + rx_data;
          state_d    = S_CNT_H;
        end
        S_CNT_H: begin
          cnt_d = cnt_full;
          sum_d = sum_q + rx_data;
          if ({16'd0, cnt_full} > 32'(MEM_WORDS)) begin
            state_d = S_ERROR;
            err_d   = ERR_COUNT;
            busy_d  = 1'b0;
          end else if (cnt_full == 16'd0) begin
            state_d = S_CSUM;
          end else begin
            state_d    = S_DATA;
            byte_idx_d = 2'd0;
            word_idx_d = 16'd0;
          end
        end
        S_DATA: begin
          sum_d      = sum_q + rx_data;
          byte_idx_d = byte_idx_q + 2'd1;
          case (byte_idx_q)
            2'd0: wbuf_d[7:0]   = rx_data;
            2'd1: wbuf_d[15:8]  = rx_data;
            2'd2: wbuf_d[23:16] = rx_data;
            default: begin
              wen_d      = 1'b1;
              waddr_d    = 32'(BASE_WORD) + {16'd0, word_idx_q};
              wdata_d    = {rx_data, wbuf_q};
              word_idx_d = word_idx_q + 16'd1;
              if (word_idx_q == cnt_q - 16'd1) begin
                state_d = S_CSUM;
              end
            end
          endcase
        end
        S_CSUM: begin
          busy_d = 1'b0;
          if (rx_data == sum_q) begin
            state_d   = S_DONE;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            // cpu_rst stays high: a partially verified image must not run.
            state_d = S_ERROR;
            err_d   = ERR_CSUM;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and output registers; reset returns to IDLE with the CPU running.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      word_idx_q <= '0;
      byte_idx_q <= '0;
      wbuf_q     <= '0;
      sum_q      <= '0;
      tmo_q      <= '0;
      wen_q      <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= ERR_NONE;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_idx_q <= word_idx_d;
      byte_idx_q <= byte_idx_d;
      wbuf_q     <= wbuf_d;
      sum_q      <= sum_d;
      tmo_q      <= tmo_d;
      wen_q      <= wen_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

endmodule
